edge_event_arbiter: RTL

//  Multi-channel edge-event collector. Detects per-channel rising/falling edges on N

---
 rtl/edge_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/edge_event_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/edge_pkg.sv
// Shared encodings for the edge-event collector: per-channel mode and arbiter FSM states.
package edge_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } mode_e;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requesting channel at or after ptr, wrapping N-1 -> 0.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int CW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] ptr,
    output logic [CW-1:0] grant,
    output logic          any_req
);

    int idx;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant   = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx] && !any_req) begin
                any_req = 1'b1;
                grant   = CW'(idx);
            end
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Detects qualified edges on N synchronous inputs, latches them as pending events and
// delivers them one at a time over a valid/ready port shared round-robin between channels.
module edge_event_arbiter #(
    parameter int N     = 4,
    parameter int CW    = $clog2(N),
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [N-1:0]     din,
    input  logic [2*N-1:0]   mode,
    input  logic             evt_ready,
    input  logic             clr_ovf,
    output logic             evt_valid,
    output logic [CW-1:0]    evt_ch,
    output logic             evt_rise,
    output logic [N-1:0]     ovf,
    output logic [CNT_W-1:0] evt_cnt
);

    import edge_pkg::*;

    logic [N-1:0]     din_q;
    logic             armed;
    logic [N-1:0]     rise;
    logic [N-1:0]     fall;
    logic [N-1:0]     hit;
    logic [N-1:0]     own_accept;
    logic [N-1:0]     set_ovf;
    logic [N-1:0]     pending;
    logic [N-1:0]     pol;
    logic [N-1:0]     ovf_q;
    logic [CW-1:0]    rr_ptr;
    logic [CW-1:0]    grant;
    logic [CW-1:0]    ch_q;
    logic             rise_q;
    logic             any_req;
    logic             accept;
    logic             load_evt;
    logic [CNT_W-1:0] cnt;
    state_e           state;
    state_e           state_next;
    mode_e            ch_mode;

    // armed stays low for the first clock after reset so din_q can load without a false edge.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            din_q <= '0;
            armed <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            din_q <= din;
            armed <= 1'b1;
        end
    end

    assign accept = (state == PRESENT) && evt_ready;

    always_comb begin
        rise       = '0;
        fall       = '0;
        own_accept = '0;
        set_ovf    = '0;
        ch_mode    = MODE_OFF;
        for (int i = 0; i < N; i++) begin
            ch_mode       = mode_e'(mode[2*i +: 2]);
            rise[i]       = armed && din[i] && !din_q[i] && (ch_mode == MODE_RISE || ch_mode == MODE_BOTH);
            fall[i]       = armed && !din[i] && din_q[i] && (ch_mode == MODE_FALL || ch_mode == MODE_BOTH);
            own_accept[i] = accept && (ch_q == CW'(i));
            set_ovf[i]    = (rise[i] || fall[i]) && pending[i] && !own_accept[i];
        end
    end

    assign hit = rise | fall;

    // A second edge on a still-pending channel is lost; one landing in its accept cycle replaces it.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            pol     <= '0;
            ovf_q   <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (hit[i] && !set_ovf[i]) begin
                    pending[i] <= 1'b1;
                    pol[i]     <= rise[i];
                end else if (own_accept[i]) begin
                    pending[i] <= 1'b0;
                end
                if (set_ovf[i]) begin
                    ovf_q[i] <= 1'b1;
                end else if (clr_ovf) begin
                    ovf_q[i] <= 1'b0;
                end
            end
        end
    end

    rr_arbiter #(.N(N), .CW(CW)) u_rr (
        .req     (pending),
        .ptr     (rr_ptr),
        .grant   (grant),
        .any_req (any_req)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_evt   = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    load_evt   = 1'b1;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (evt_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            ch_q   <= '0;
            rise_q <= 1'b0;
            rr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (load_evt) begin
                ch_q   <= grant;
                rise_q <= pol[grant];
            end
            if (accept) begin
                cnt    <= cnt + CNT_W'(1);
                rr_ptr <= (ch_q == CW'(N - 1)) ? '0 : ch_q + CW'(1);
            end
        end
    end

    assign evt_valid = (state == PRESENT);
    assign evt_ch    = ch_q;
    assign evt_rise  = rise_q;
    assign ovf       = ovf_q;
    assign evt_cnt   = cnt;

endmodule
